// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB stage: widths, RV32 opcodes and load funct3 codes,
// FSM states and the destination-write decode.
package mem_wb_stage_pkg;

   localparam int CPU_DATA_BITS = 32;
   localparam int CPU_ADDR_BITS = 32;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic writes_rd(input logic [6:0] opc);
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
         OPC_OP, OPC_OPIMM, OPC_LOAD: return 1'b1;
         default:                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-cache request/response bus between the MEM/WB stage (master) and the dcache (slave).
interface mem_wb_stage_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              dc_req_valid;
   logic              dc_req_ready;
   logic [ADDR_W-1:0] dc_addr;
   logic [DATA_W-1:0] dc_din;
   logic [3:0]        dc_we;
   logic              dc_resp_valid;
   logic [DATA_W-1:0] dc_dout;

   modport master (
      output dc_req_valid, dc_addr, dc_din, dc_we,
      input  dc_req_ready, dc_resp_valid, dc_dout
   );

   modport slave (
      input  dc_req_valid, dc_addr, dc_din, dc_we,
      output dc_req_ready, dc_resp_valid, dc_dout
   );
endinterface

// File: rtl/mem_wb_stage_load_extract.sv
// Load data extraction: selects the byte/halfword by address offset and sign- or zero-extends.
module load_extract
   import mem_wb_stage_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_BITS
) (
   input  logic [DATA_W-1:0] word,
   input  logic [1:0]        offset,
   input  logic [2:0]        funct3,
   output logic [DATA_W-1:0] data
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Halfwords ignore offset[0]: a misaligned LH reads the aligned half that contains it.
   always_comb begin
      byte_sel = word[{offset, 3'b000} +: 8];
      half_sel = offset[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_LB:   data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         F3_LBU:  data = {{(DATA_W-8){1'b0}}, byte_sel};
         F3_LH:   data = {{(DATA_W-16){half_sel[15]}}, half_sel};
         F3_LHU:  data = {{(DATA_W-16){1'b0}}, half_sel};
         default: data = word;
      endcase
   end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: holds one instruction in the M register, runs its dcache access
// and produces the register-file write in the retire cycle.
//
//   state   | meaning
//   IDLE    | no access in flight; non-memory instruction in M retires here
//   REQ     | dcache request presented, waiting for dc_req_ready
//   RESP    | load accepted by dcache, waiting for dc_resp_valid
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_BITS,
   parameter int ADDR_W = CPU_ADDR_BITS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [31:0]       inst_EX,
   input  logic [ADDR_W-1:0] pc_EX,
   input  logic [DATA_W-1:0] ALU,
   input  logic [DATA_W-1:0] Data_W,
   input  logic [3:0]        dcache_we,
   mem_wb_stage_if.master    dc,
   output logic              wrt_en,
   output logic [4:0]        wrt_addr,
   output logic [DATA_W-1:0] dataD,
   output logic [DATA_W-1:0] WB_data,
   output logic [DATA_W-1:0] ALU_WB
);
   state_t            state, state_nxt;
   logic              m_valid;
   logic [31:0]       m_inst;
   logic [ADDR_W-1:0] m_pc;
   logic [DATA_W-1:0] m_alu;
   logic [DATA_W-1:0] m_din;
   logic [3:0]        m_we;

   logic [6:0]        opcode;
   logic              is_load, is_store, mem_op;
   logic              retire, capture, req_valid;
   logic [ADDR_W-1:0] pc_plus4;
   logic [DATA_W-1:0] ld_data;
   logic              unused_inst_hi;

   assign opcode         = m_inst[6:0];
   assign is_load        = (opcode == OPC_LOAD);
   assign is_store       = (opcode == OPC_STORE);
   assign mem_op         = is_load || is_store;
   assign capture        = ex_valid && ex_ready;
   assign pc_plus4       = m_pc + ADDR_W'(4);
   assign unused_inst_hi = ^m_inst[31:15];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         m_valid <= 1'b0;
         m_inst  <= '0;
         m_pc    <= '0;
         m_alu   <= '0;
         m_din   <= '0;
         m_we    <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            m_valid <= 1'b1;
            m_inst  <= inst_EX;
            m_pc    <= pc_EX;
            m_alu   <= ALU;
            m_din   <= Data_W;
            m_we    <= dcache_we;
         end else if (retire) begin
            m_valid <= 1'b0;
         end
      end
   end

   // Handshake inputs are only looked at in the state that expects them.
   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      req_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            if (m_valid) begin
               if (mem_op) state_nxt = ST_REQ;
               else        retire    = 1'b1;
            end
         end
         ST_REQ: begin
            req_valid = 1'b1;
            if (dc.dc_req_ready) begin
               if (is_store) begin
                  retire    = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (dc.dc_resp_valid) begin
               retire    = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      ex_ready = retire || ((state == ST_IDLE) && !(m_valid && mem_op));
   end

   assign dc.dc_req_valid = req_valid;
   assign dc.dc_addr      = ADDR_W'(m_alu);
   assign dc.dc_din       = m_din;
   assign dc.dc_we        = is_store ? m_we : 4'b0000;

   load_extract #(.DATA_W(DATA_W)) u_load_extract (
      .word   (dc.dc_dout),
      .offset (m_alu[1:0]),
      .funct3 (m_inst[14:12]),
      .data   (ld_data)
   );

   always_comb begin
      case (opcode)
         OPC_LOAD:           dataD = ld_data;
         OPC_JAL, OPC_JALR:  dataD = DATA_W'(pc_plus4);
         default:            dataD = m_alu;
      endcase
   end

   assign wrt_en   = retire && writes_rd(opcode) && (m_inst[11:7] != 5'd0);
   assign wrt_addr = m_inst[11:7];
   assign WB_data  = dataD;
   assign ALU_WB   = m_alu;
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: MEM_WB_stage

Interface
REQ-001 SHALL have parameter DATA_W, default `CPU_DATA_BITS (32), datapath width.
REQ-002 SHALL have parameter ADDR_W, default `CPU_ADDR_BITS (32), address width.
REQ-003 SHALL have one clock and asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 ex_valid  in  1  EX holds a valid instruction this cycle.
REQ-006 ex_ready  out  1  stage accepts the EX instruction at the next edge.
REQ-007 inst_EX  in  32  EX instruction; pc_EX  in  ADDR_W  EX PC.
REQ-008 ALU  in  DATA_W  EX ALU result, which is also the memory address.
REQ-009 Data_W  in  DATA_W  aligned store data; dcache_we  in  4  store byte enables.
REQ-010 dc_req_valid  out  1; dc_req_ready  in  1  dcache request handshake.
REQ-011 dc_addr  out  ADDR_W; dc_din  out  DATA_W; dc_we  out  4 (all-zero = read).
REQ-012 dc_resp_valid  in  1; dc_dout  in  DATA_W  load response word.
REQ-013 wrt_en  out  1; wrt_addr  out  5; dataD  out  DATA_W  RegFile write port.
REQ-014 WB_data  out  DATA_W, equal to dataD, forwarded to EX; ALU_WB  out  DATA_W, the registered ALU result forwarded to EX.

Function
REQ-015 The M register (valid, inst, pc, alu, store data, we) SHALL load at any edge where ex_valid && ex_ready.
REQ-016 The FSM SHALL have states IDLE, REQ and RESP; reset SHALL force IDLE.
REQ-017 IDLE: if the captured instruction is LOAD or STORE, go to REQ; otherwise retire it in the cycle after capture.
REQ-018 REQ: hold dc_req_valid=1 with stable addr, din and we until dc_req_ready; a store then retires, and a load goes to RESP.
REQ-019 RESP: wait for dc_resp_valid; the load retires in that same cycle and the FSM returns to IDLE.
REQ-020 ex_ready SHALL be 1 in IDLE with no memory op pending, and 1 in the retiring cycle; it SHALL be 0 otherwise, for back-to-back issue.
REQ-021 Load extraction SHALL use alu[1:0] and funct3: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-022 Misaligned halfword and word loads SHALL use the aligned word (alu[1:0] ignored for LW; alu[0] ignored for LH/LHU), with no trap.
REQ-023 dataD SHALL be the extracted load for LOAD, pc+4 for JAL/JALR, and alu for all other cases.
REQ-024 wrt_en=1 SHALL be asserted only in the retire cycle, for LUI, AUIPC, JAL, JALR, OP, OP-IMM or LOAD, and only when inst[11:7]!=0.
REQ-025 Store, branch and SYSTEM instructions SHALL never assert wrt_en.
REQ-026 dc_resp_valid outside RESP SHALL be ignored.
REQ-027 dc_req_ready outside REQ SHALL be ignored.
REQ-028 When capture and retire occur on the same edge, the new instruction SHALL overwrite M with no bubble.
REQ-029 pc+4 SHALL wrap modulo 2^ADDR_W.

Reset
REQ-030 Reset SHALL clear the M valid bit and set FSM=IDLE.
REQ-031 Under reset, outputs SHALL be: ex_ready=1, dc_req_valid=0, dc_we=0, wrt_en=0, wrt_addr=0, dataD=0, ALU_WB=0.
REQ-032 Reset asserted mid-REQ or mid-RESP SHALL abandon the access, with no writeback and no later consumption of dcache data.

Structure
REQ-033 Opcode, funct3 and FSM state encodings SHALL live in the shared package alongside const.vh.
REQ-034 Load extraction SHALL be a combinational sub-module load_extract (inputs: word, offset, funct3; output: DATA_W).

Verification
REQ-035 ADD x5 with alu=0x1234 -> wrt_en=1, wrt_addr=5 and dataD=0x1234 in the cycle after capture; ex_ready stays 1.
REQ-036 LB at alu=0x103, dc_dout=0x80FF_FF00, response 2 cycles after req_ready -> dataD=0xFFFF_FF80, with ex_ready=0 until retire.
REQ-037 SW at alu=0x200, we=0xF, dc_req_ready held low 3 cycles -> dc_addr, dc_din and dc_we stable throughout, and no wrt_en.
REQ-038 JAL x1 at pc=0xFFFF_FFFC -> dataD=0x0000_0000.
REQ-039 ADDI x0 -> wrt_en=0.
REQ-040 Reset asserted in RESP, then a stray dc_resp_valid -> FSM=IDLE, wrt_en=0, ex_ready=1.
